// File: rtl/mem_pkg.sv
// Shared types for the core data-memory path: word addresses and buffered store entries.
package mem_pkg;

  localparam int unsigned MEM_AW      = 32;
  localparam int unsigned MEM_DW      = 32;
  localparam int unsigned STORE_DEPTH = 4;

  typedef logic [MEM_AW-3:0] word_addr_t;

  typedef struct packed {
    word_addr_t              addr;
    logic [MEM_DW-1:0]       data;
  } store_entry_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular buffer of pending stores with per-entry valid bits and a youngest-first age order.
module store_fifo
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = STORE_DEPTH,
  parameter int unsigned IW    = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_push,
  input  store_entry_t                   i_entry,
  input  logic                           i_pop,
  output logic                           o_full,
  output logic                           o_empty,
  output store_entry_t [DEPTH-1:0]       o_entries,
  output logic         [DEPTH-1:0]       o_valid,
  output logic         [DEPTH-1:0][IW-1:0] o_age_idx,
  output store_entry_t                   o_head
);

  localparam int unsigned PW = IW + 1;

  logic         [PW-1:0]    r_wr_ptr;
  logic         [PW-1:0]    r_rd_ptr;
  logic         [DEPTH-1:0] r_valid;
  store_entry_t [DEPTH-1:0] r_mem;

  logic [IW-1:0] w_wr_idx;
  logic [IW-1:0] w_rd_idx;
  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_wr_idx  = r_wr_ptr[IW-1:0];
  assign w_rd_idx  = r_rd_ptr[IW-1:0];
  assign w_full    = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) && (w_wr_idx == w_rd_idx);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~w_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_valid  <= '0;
    end else begin
      // Push and pop never target the same slot: that would need full and empty at once.
      if (w_do_push) begin
        r_wr_ptr           <= r_wr_ptr + 1'b1;
        r_valid[w_wr_idx]  <= 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr           <= r_rd_ptr + 1'b1;
        r_valid[w_rd_idx]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= i_entry;
    end
  end

  always_comb begin
    o_age_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      o_age_idx[k] = w_wr_idx - IW'(k + 1);
    end
  end

  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_entries = r_mem;
  assign o_valid   = r_valid;
  assign o_head    = r_mem[w_rd_idx];

endmodule

// File: rtl/store_buffer.sv
// Core data-port responder: buffers stores, drains them in order to backing memory, forwards to loads.
module store_buffer
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = STORE_DEPTH,
  parameter int unsigned AW    = MEM_AW,
  parameter int unsigned DW    = MEM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] readdata_o,
  output logic          stall_o,
  output logic          empty_o,
  output logic [AW-3:0] bk_raddr_o,
  input  logic [DW-1:0] bk_rdata_i,
  output logic          bk_wvalid_o,
  input  logic          bk_wready_i,
  output logic [AW-3:0] bk_waddr_o,
  output logic [DW-1:0] bk_wdata_o
);

  localparam int unsigned IW = $clog2(DEPTH);

  word_addr_t                    w_word;
  store_entry_t                  w_new;
  store_entry_t                  w_head;
  store_entry_t [DEPTH-1:0]      w_entries;
  logic         [DEPTH-1:0]      w_valid;
  logic         [DEPTH-1:0][IW-1:0] w_age;
  logic                          w_full;
  logic                          w_empty;
  logic                          w_push;
  logic                          w_pop;
  logic         [DW-1:0]         w_rdata;
  logic                          w_unused;

  assign w_word   = addr_i[AW-1:2];
  assign w_unused = &{1'b0, addr_i[1:0]};
  assign w_new    = '{addr: w_word, data: wdata_i};

  // Stall comes from occupancy only, so bk_wready_i never reaches the core combinationally.
  assign w_push = memwrite_i & ~w_full;
  assign w_pop  = bk_wready_i & ~w_empty;

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_entry   (w_new),
    .i_pop     (w_pop),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_entries (w_entries),
    .o_valid   (w_valid),
    .o_age_idx (w_age),
    .o_head    (w_head)
  );

  // Oldest to youngest, so the youngest matching entry wins.
  always_comb begin
    w_rdata = bk_rdata_i;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (w_valid[w_age[IW'(DEPTH - 1 - i)]] &&
          (w_entries[w_age[IW'(DEPTH - 1 - i)]].addr == w_word)) begin
        w_rdata = w_entries[w_age[IW'(DEPTH - 1 - i)]].data;
      end
    end
  end

  assign readdata_o  = w_rdata;
  assign stall_o     = memwrite_i & w_full;
  assign empty_o     = w_empty;
  assign bk_raddr_o  = w_word;
  assign bk_wvalid_o = ~w_empty;
  assign bk_waddr_o  = w_head.addr;
  assign bk_wdata_o  = w_head.data;

endmodule
